// File: rtl/mem_defs.sv
// Shared definitions for the memory-access stage: FSM state encodings and
// the default ack timeout.
package mem_defs;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int MAX_WAIT_DEFAULT = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts ACCESS cycles without an ack; expired flags the last allowed wait cycle.
module mem_wait_timer
  import mem_defs::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The counter starts at 0 on the first ACCESS cycle, so reaching
  // MAX_WAIT-1 means this is wait cycle number MAX_WAIT.
  assign expired = (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards ALU results, issues data-memory
// requests with an ack timeout. Optional alignment check: MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access
  import mem_defs::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] db,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        mem_err,
  output logic        misalign
);

  state_t     state;
  logic       is_load;
  logic       regwrite_q;
  logic [4:0] rd_q;
  logic       expired;
  logic       misaligned;
  logic       mem_op;

  assign mem_op = MemRead || MemWrite;
  assign stall  = (state == ACCESS);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = |ALUResult[1:0];
`else
  assign misaligned = 1'b0;
`endif

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .count   ((state == ACCESS) && !dmem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      out_valid   <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= '0;
      wb_regwrite <= 1'b0;
      mem_err     <= 1'b0;
      misalign    <= 1'b0;
      is_load     <= 1'b0;
      regwrite_q  <= 1'b0;
      rd_q        <= '0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      out_valid   <= 1'b0;
      wb_regwrite <= 1'b0;
      mem_err     <= 1'b0;
      misalign    <= 1'b0;

      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!mem_op) begin
              out_valid   <= 1'b1;
              wb_data     <= ALUResult;
              wb_rd       <= rd;
              wb_regwrite <= RegWrite;
            end else if (misaligned) begin
              misalign  <= 1'b1;
              out_valid <= 1'b1;
              wb_rd     <= rd;
            end else begin
              // A store wins when both MemRead and MemWrite are set.
              state      <= ACCESS;
              dmem_req   <= 1'b1;
              dmem_we    <= MemWrite;
              dmem_addr  <= ALUResult;
              dmem_wdata <= db;
              is_load    <= !MemWrite;
              regwrite_q <= RegWrite;
              rd_q       <= rd;
            end
          end
        end

        ACCESS: begin
          if (dmem_ack) begin
            state       <= IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            out_valid   <= 1'b1;
            wb_rd       <= rd_q;
            wb_regwrite <= is_load && regwrite_q;
            if (is_load) begin
              wb_data <= dmem_rdata;
            end
          end else if (expired) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            mem_err   <= 1'b1;
            out_valid <= 1'b1;
            wb_rd     <= rd_q;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
